// File: rtl/dualmem_ctl.sv
// Purpose : single-clock true dual-port RAM, per-byte writes, same-address merge, zero-init after reset.
// Latency : reads return 1 cycle after the accepting edge (2 with OUT_REG=1); writes visible next edge.
// Backpr. : none; one request per port per cycle, requests ignored until init_done.
//
// Ports:
//   clk, rstn              single clock, asynchronous active-low reset
//   ena/enb                request strobes; wea/web byte enables (zero = read)
//   addra/addrb            word addresses; dina/dinb write data
//   douta/doutb            read data, held between rvalid pulses
//   rvalida/rvalidb        one-cycle read-data-valid pulses
//   init_done              high once the memory has been cleared
//   collision, coll_cnt    write/write byte-overlap pulse and saturating event count
module dualmem_ctl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int OUT_REG    = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ena,
  input  logic                      enb,
  input  logic [DATA_WIDTH/8-1:0]   wea,
  input  logic [DATA_WIDTH/8-1:0]   web,
  input  logic [ADDR_WIDTH-1:0]     addra,
  input  logic [ADDR_WIDTH-1:0]     addrb,
  input  logic [DATA_WIDTH-1:0]     dina,
  input  logic [DATA_WIDTH-1:0]     dinb,
  output logic [DATA_WIDTH-1:0]     douta,
  output logic [DATA_WIDTH-1:0]     doutb,
  output logic                      rvalida,
  output logic                      rvalidb,
  output logic                      init_done,
  output logic                      collision,
  output logic [15:0]               coll_cnt
);

  localparam int BE    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_q, state_d;
  // One bit wider than the address so the terminal value DEPTH marks "all words cleared".
  logic [ADDR_WIDTH:0]     init_cnt;
  logic                    init_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
  logic                    same_addr, coll_hit;
  logic [DATA_WIDTH-1:0]   rdat_a, rdat_b;
  logic [DATA_WIDTH-1:0]   d1a, d1b;
  logic                    v1a, v1b;

  // ---------------------------------------------------------------- init FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (init_we) init_cnt <= init_cnt + (ADDR_WIDTH+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt[ADDR_WIDTH]) state_d = READY;
        else                      init_we = 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign init_done = (state_q == READY);

  // ---------------------------------------------------------------- request decode
  assign acc_a     = ena & init_done;
  assign acc_b     = enb & init_done;
  assign wr_a      = acc_a & (|wea);
  assign wr_b      = acc_b & (|web);
  assign rd_a      = acc_a & ~(|wea);
  assign rd_b      = acc_b & ~(|web);
  assign same_addr = (addra == addrb);
  assign coll_hit  = wr_a & wr_b & same_addr & (|(wea & web));

  // ---------------------------------------------------------------- storage
  // Port B bytes are assigned before port A so that, on overlapping bytes of the
  // same word, the later non-blocking assignment (port A) is the one that lands.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int r = 0; r < BE; r++) begin
        if (wr_b && web[r]) mem[addrb][8*r +: 8] <= dinb[8*r +: 8];
        if (wr_a && wea[r]) mem[addra][8*r +: 8] <= dina[8*r +: 8];
      end
    end
  end

  // Read path: stored word with the other port's same-cycle write bytes forwarded in.
  always_comb begin
    rdat_a = mem[addra];
    rdat_b = mem[addrb];
    for (int r = 0; r < BE; r++) begin
      if (wr_b && same_addr && web[r]) rdat_a[8*r +: 8] = dinb[8*r +: 8];
      if (wr_a && same_addr && wea[r]) rdat_b[8*r +: 8] = dina[8*r +: 8];
    end
  end

  // ---------------------------------------------------------------- first read stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1a <= 1'b0;
      v1b <= 1'b0;
      d1a <= '0;
      d1b <= '0;
    end else begin
      v1a <= rd_a;
      v1b <= rd_b;
      if (rd_a) d1a <= rdat_a;
      if (rd_b) d1b <= rdat_b;
    end
  end

  // ---------------------------------------------------------------- optional output stage
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] d2a, d2b;
      logic                  v2a, v2b;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v2a <= 1'b0;
          v2b <= 1'b0;
          d2a <= '0;
          d2b <= '0;
        end else begin
          v2a <= v1a;
          v2b <= v1b;
          if (v1a) d2a <= d1a;
          if (v1b) d2b <= d1b;
        end
      end
      assign douta   = d2a;
      assign doutb   = d2b;
      assign rvalida = v2a;
      assign rvalidb = v2b;
    end else begin : g_noreg
      assign douta   = d1a;
      assign doutb   = d1b;
      assign rvalida = v1a;
      assign rvalidb = v1b;
    end
  endgenerate

  // ---------------------------------------------------------------- collision tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      collision <= 1'b0;
      coll_cnt  <= '0;
    end else begin
      collision <= coll_hit;
      if (coll_hit && (coll_cnt != 16'hFFFF)) coll_cnt <= coll_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dualmem_ctl.sv
// Directed bench for dualmem_ctl: two instances (OUT_REG=0 and OUT_REG=1) share stimulus;
// expected read data is queued with its due cycle and checked by a per-port monitor.
module tb_dualmem_ctl;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          ena = 1'b0, enb = 1'b0;
  logic [7:0]    wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0, dinb = '0;

  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          rvalida0, rvalidb0, rvalida1, rvalidb1;
  logic          init_done0, init_done1, collision0, collision1;
  logic [15:0]   coll_cnt0, coll_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit ready  = 0;

  typedef struct {
    int          port;   // 0/1 = u0 a/b, 2/3 = u1 a/b
    logic [63:0] d;
    int          due;
  } exp_t;
  exp_t sb[$];

  dualmem_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0)) u0 (
    .clk(clk), .rstn(rstn), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta0), .doutb(doutb0), .rvalida(rvalida0), .rvalidb(rvalidb0),
    .init_done(init_done0), .collision(collision0), .coll_cnt(coll_cnt0));

  dualmem_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1)) u1 (
    .clk(clk), .rstn(rstn), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta1), .doutb(doutb1), .rvalida(rvalida1), .rvalidb(rvalidb1),
    .init_done(init_done1), .collision(collision1), .coll_cnt(coll_cnt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every port either has its oldest expectation due now, or must be idle.
  always @(negedge clk) begin
    logic [63:0] od[4];
    logic        ov[4];
    int          idx;
    od[0] = douta0; od[1] = doutb0; od[2] = douta1; od[3] = doutb1;
    ov[0] = rvalida0; ov[1] = rvalidb0; ov[2] = rvalida1; ov[3] = rvalidb1;
    for (int p = 0; p < 4; p++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].port == p) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0 && sb[idx].due <= cyc) begin
        chk($sformatf("u%0d_%s_rvalid", p / 2, (p % 2) ? "b" : "a"), {63'b0, ov[p]}, 64'd1);
        chk($sformatf("u%0d_%s_rdata", p / 2, (p % 2) ? "b" : "a"), od[p], sb[idx].d);
        sb.delete(idx);
      end else begin
        chk($sformatf("u%0d_%s_rvalid_idle", p / 2, (p % 2) ? "b" : "a"), {63'b0, ov[p]}, 64'd0);
      end
    end
  end

  task automatic push_rd(input int pb, input logic [63:0] d);
    exp_t e;
    e.port = pb;     e.d = d; e.due = cyc + 1; sb.push_back(e);
    e.port = pb + 2; e.d = d; e.due = cyc + 2; sb.push_back(e);
  endtask

  // Drive one request cycle; xa/xb are the expected read results for read requests.
  task automatic req(input logic ea, input logic [7:0] wa, input logic [3:0] aa, input logic [63:0] da,
                     input logic eb, input logic [7:0] wb, input logic [3:0] ab, input logic [63:0] db,
                     input logic [63:0] xa, input logic [63:0] xb);
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    if (ready && ea && wa == 8'h00) push_rd(0, xa);
    if (ready && eb && wb == 8'h00) push_rd(1, xb);
  endtask

  task automatic idle();
    @(negedge clk);
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_douta0"}, douta0, 64'd0);
    chk({tag, "_doutb0"}, doutb0, 64'd0);
    chk({tag, "_douta1"}, douta1, 64'd0);
    chk({tag, "_doutb1"}, doutb1, 64'd0);
    chk({tag, "_rvalid"}, {60'b0, rvalida0, rvalidb0, rvalida1, rvalidb1}, 64'd0);
    chk({tag, "_init_done"}, {62'b0, init_done0, init_done1}, 64'd0);
    chk({tag, "_collision"}, {62'b0, collision0, collision1}, 64'd0);
    chk({tag, "_coll_cnt0"}, {48'b0, coll_cnt0}, 64'd0);
    chk({tag, "_coll_cnt1"}, {48'b0, coll_cnt1}, 64'd0);
  endtask

  // Release reset and step through INIT while hammering both ports with requests
  // that must be ignored. abort_at>0 re-asserts reset after that many edges.
  task automatic init_run(input int abort_at);
    @(negedge clk);
    rstn  = 1'b1;
    ready = 0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      ena = 1'b1; wea = 8'hFF; addra = 4'(i); dina = '1;
      enb = 1'b1; web = 8'h00; addrb = 4'(i);
      @(negedge clk);
      if (abort_at == i) begin
        #1;
        rstn = 1'b0;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        #1;
        chk_reset("abort_init");
        return;
      end
      chk($sformatf("init_done_u0_edge%0d", i), {63'b0, init_done0}, (i > DEPTH) ? 64'd1 : 64'd0);
      chk($sformatf("init_done_u1_edge%0d", i), {63'b0, init_done1}, (i > DEPTH) ? 64'd1 : 64'd0);
    end
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    ready = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");

    // INIT interrupted at count 8, then a complete INIT.
    init_run(8);
    repeat (2) @(negedge clk);
    init_run(0);

    // Whole memory reads zero on both ports, back-to-back.
    for (int i = 0; i < DEPTH; i++)
      req(1, 8'h00, 4'(i), '0, 1, 8'h00, 4'(DEPTH - 1 - i), '0, 64'd0, 64'd0);
    idle();

    // Byte-enable write then read on the other port.
    req(1, 8'h0F, 4'd3, 64'h1122334455667788, 0, 8'h00, 4'd0, '0, '0, '0);
    req(0, 8'h00, 4'd0, '0, 1, 8'h00, 4'd3, '0, '0, 64'h0000000055667788);
    idle();

    // Write/write collision with overlapping bytes.
    req(1, 8'hFF, 4'd5, 64'hAAAAAAAAAAAAAAAA, 1, 8'hF0, 4'd5, 64'hBBBBBBBBBBBBBBBB, '0, '0);
    idle();
    chk("coll_pulse", {62'b0, collision0, collision1}, 64'd3);
    chk("coll_cnt0_1", {48'b0, coll_cnt0}, 64'd1);
    chk("coll_cnt1_1", {48'b0, coll_cnt1}, 64'd1);
    idle();
    chk("coll_pulse_once", {62'b0, collision0, collision1}, 64'd0);
    req(1, 8'h00, 4'd5, '0, 0, 8'h00, 4'd0, '0, 64'hAAAAAAAAAAAAAAAA, '0);

    // Disjoint byte enables: merge, no collision.
    req(1, 8'h0F, 4'd5, 64'hAAAAAAAAAAAAAAAA, 1, 8'hF0, 4'd5, 64'hBBBBBBBBBBBBBBBB, '0, '0);
    idle();
    chk("no_coll_pulse", {62'b0, collision0, collision1}, 64'd0);
    chk("coll_cnt0_hold", {48'b0, coll_cnt0}, 64'd1);
    chk("coll_cnt1_hold", {48'b0, coll_cnt1}, 64'd1);
    req(0, 8'h00, 4'd0, '0, 1, 8'h00, 4'd5, '0, '0, 64'hBBBBBBBBAAAAAAAA);

    // Read/write forwarding in both directions, and read/read.
    req(1, 8'h00, 4'd7, '0, 1, 8'h01, 4'd7, 64'h00000000000000FF, 64'h00000000000000FF, '0);
    req(1, 8'h00, 4'd7, '0, 1, 8'h00, 4'd7, '0, 64'h00000000000000FF, 64'h00000000000000FF);
    req(1, 8'h02, 4'd7, 64'h000000000000EE00, 1, 8'h00, 4'd7, '0, '0, 64'h000000000000EEFF);
    req(1, 8'h00, 4'd7, '0, 1, 8'h00, 4'd3, '0, 64'h000000000000EEFF, 64'h0000000055667788);
    idle();
    repeat (3) idle();

    // Reset one cycle after a read: u0 has already delivered, u1 must never deliver.
    req(1, 8'h00, 4'd3, '0, 0, 8'h00, 4'd0, '0, 64'h0000000055667788, '0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    sb.delete();
    ready = 0;
    #1;
    chk_reset("abort_read");
    repeat (2) @(negedge clk);
    init_run(0);

    // Memory was cleared again by the second INIT.
    req(1, 8'h00, 4'd3, '0, 1, 8'h00, 4'd5, '0, 64'd0, 64'd0);
    req(1, 8'h00, 4'd7, '0, 1, 8'h00, 4'd0, '0, 64'd0, 64'd0);
    idle();
    repeat (4) idle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
